mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mdu_pkg.sv | 16 +
 rtl/mdu_abs.sv | 12 +
 rtl/mult_div_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation select and FSM states.
package mdu_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } stateT;

endpackage

// File: rtl/mdu_abs.sv
// Conditional two's-complement negate; gives operand magnitudes and signed result fixup.
module mdu_abs #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] value,
   input  logic             negate,
   output logic [WIDTH-1:0] result
);

   assign result = negate ? ({WIDTH{1'b0}} - value) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit (signed and unsigned, full 2*WIDTH product).
// The divide datapath is present only when MULT_DIV_UNIT_DIV_EN is defined.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   stateT            stateReg;
   logic [CW-1:0]    countReg;
   logic [WIDTH-1:0] accReg, lowReg, opndReg;
   logic             negResReg;
   logic             busyReg, doneReg, divZeroReg;
   logic [WIDTH-1:0] hiReg, loReg;

   logic             negA, negB, skipNow, divZeroNow;
   logic [WIDTH-1:0] aMag, bMag;
   logic [2*WIDTH-1:0] prodFixed;
   logic [WIDTH:0]   sumVal;
   logic [WIDTH-1:0] accNext, lowNext;

   // Only the signed ops (op[0] == 0) treat the top bit as a sign.
   assign negA = ~op[0] & a[WIDTH-1];
   assign negB = ~op[0] & b[WIDTH-1];

   mdu_abs #(.WIDTH(WIDTH)) aAbs (.value(a), .negate(negA), .result(aMag));
   mdu_abs #(.WIDTH(WIDTH)) bAbs (.value(b), .negate(negB), .result(bMag));
   mdu_abs #(.WIDTH(2*WIDTH)) prodFix (
      .value({accReg, lowReg}), .negate(negResReg), .result(prodFixed)
   );

`ifdef MULT_DIV_UNIT_DIV_EN
   logic             isDivReg, negRemReg;
   logic [WIDTH:0]   shiftVal;
   logic [WIDTH-1:0] quoFixed, remFixed;

   mdu_abs #(.WIDTH(WIDTH)) quoFix (.value(lowReg), .negate(negResReg), .result(quoFixed));
   mdu_abs #(.WIDTH(WIDTH)) remFix (.value(accReg), .negate(negRemReg), .result(remFixed));

   assign divZeroNow = op[1] && (b == '0);
   assign skipNow    = divZeroNow;
`else
   assign divZeroNow = 1'b0;
   assign skipNow    = op[1];
`endif

   // One radix-2 step: {acc,low} holds partial product / (remainder, quotient).
   always_comb begin
      sumVal = {1'b0, accReg} + {1'b0, (lowReg[0] ? opndReg : {WIDTH{1'b0}})};
      {accNext, lowNext} = {sumVal, lowReg[WIDTH-1:1]};
`ifdef MULT_DIV_UNIT_DIV_EN
      shiftVal = {accReg, lowReg[WIDTH-1]};
      if (isDivReg) begin
         if (shiftVal >= {1'b0, opndReg}) begin
            accNext = shiftVal[WIDTH-1:0] - opndReg;
            lowNext = {lowReg[WIDTH-2:0], 1'b1};
         end else begin
            accNext = shiftVal[WIDTH-1:0];
            lowNext = {lowReg[WIDTH-2:0], 1'b0};
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateReg   <= IDLE;
         countReg   <= '0;
         accReg     <= '0;
         lowReg     <= '0;
         opndReg    <= '0;
         negResReg  <= 1'b0;
         busyReg    <= 1'b0;
         doneReg    <= 1'b0;
         divZeroReg <= 1'b0;
         hiReg      <= '0;
         loReg      <= '0;
`ifdef MULT_DIV_UNIT_DIV_EN
         isDivReg   <= 1'b0;
         negRemReg  <= 1'b0;
`endif
      end else begin
         doneReg    <= 1'b0;
         divZeroReg <= 1'b0;
         case (stateReg)
            IDLE: begin
               if (start && skipNow) begin
                  stateReg   <= DONE;
                  busyReg    <= 1'b1;
                  doneReg    <= 1'b1;
                  divZeroReg <= divZeroNow;
               end else if (start) begin
                  stateReg  <= RUN;
                  busyReg   <= 1'b1;
                  countReg  <= CW'(WIDTH);
                  accReg    <= '0;
                  lowReg    <= aMag;
                  opndReg   <= bMag;
                  negResReg <= negA ^ negB;
`ifdef MULT_DIV_UNIT_DIV_EN
                  isDivReg  <= op[1];
                  negRemReg <= negA;
`endif
               end
            end
            RUN: begin
               accReg   <= accNext;
               lowReg   <= lowNext;
               countReg <= countReg - CW'(1);
               if (countReg == CW'(1)) stateReg <= FIX;
            end
            FIX: begin
`ifdef MULT_DIV_UNIT_DIV_EN
               if (isDivReg) begin
                  hiReg <= remFixed;
                  loReg <= quoFixed;
               end else begin
                  {hiReg, loReg} <= prodFixed;
               end
`else
               {hiReg, loReg} <= prodFixed;
`endif
               stateReg <= DONE;
               doneReg  <= 1'b1;
            end
            DONE: begin
               stateReg <= IDLE;
               busyReg  <= 1'b0;
            end
            default: stateReg <= IDLE;
         endcase
      end
   end

   assign busy     = busyReg;
   assign done     = doneReg;
   assign div_zero = divZeroReg;
   assign hi       = hiReg;
   assign lo       = loReg;

endmodule
